dual_port_ram: RTL and testbench



---
 rtl/ram_cfg_pkg.sv | 11 +
 rtl/dp_ram_array.sv | 26 ++
 rtl/dual_port_ram.sv | 80 ++++++++
 tb/tb_dual_port_ram.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ram_cfg_pkg.sv
// rtl/ram_cfg_pkg.sv - geometry constants and word/address types for dual_port_ram
package ram_cfg_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 12;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/dp_ram_array.sv
// rtl/dp_ram_array.sv - raw storage: synchronous write, combinational read, no reset
module dp_ram_array #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4096
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  // No reset on the array so it can map onto block RAM.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dual_port_ram.sv
// rtl/dual_port_ram.sv - simple dual-port RAM, write-first, registered out; RAM_INIT_VALID_EN adds per-word valid bits
module dual_port_ram
  import ram_cfg_pkg::*;
#(
  parameter int DATA_WIDTH = ram_cfg_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = ram_cfg_pkg::ADDR_WIDTH,
  parameter int DEPTH      = ram_cfg_pkg::DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] wr_add,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  rd,
  input  logic [ADDR_WIDTH-1:0] rd_add,
  output logic [DATA_WIDTH-1:0] out
);

  logic [DATA_WIDTH-1:0] out_q;
  logic [DATA_WIDTH-1:0] out_d;
  logic [DATA_WIDTH-1:0] arr_rdata;
  logic                  we;
  logic                  same_addr;

  // A write coinciding with reset is dropped.
  assign we        = wr & ~rst;
  assign same_addr = wr && (wr_add == rd_add);

  dp_ram_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_array (
    .clk_i  (clk),
    .we_i   (we),
    .waddr_i(wr_add),
    .wdata_i(in),
    .raddr_i(rd_add),
    .rdata_o(arr_rdata)
  );

`ifdef RAM_INIT_VALID_EN
  logic [DEPTH-1:0] valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr) begin
      valid_q[wr_add] <= 1'b1;
    end
  end
`endif

  // Bypass beats both the array and the valid check on a same-address collision.
  always_comb begin
    out_d = out_q;
    if (rd) begin
      if (same_addr) begin
        out_d = in;
      end else begin
`ifdef RAM_INIT_VALID_EN
        out_d = valid_q[rd_add] ? arr_rdata : '0;
`else
        out_d = arr_rdata;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_dual_port_ram.sv
// tb/tb_dual_port_ram.sv - directed bench with behavioural memory model and per-cycle compare
`timescale 1ns/1ps
module tb_dual_port_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr = 1'b0;
  logic [11:0] wr_add = '0;
  logic [63:0] din = '0;
  logic        rd = 1'b0;
  logic [11:0] rd_add = '0;
  logic [63:0] dout;

  int errors = 0;
  int checks = 0;

  dual_port_ram dut (
    .clk   (clk),
    .rst   (rst),
    .wr    (wr),
    .wr_add(wr_add),
    .in    (din),
    .rd    (rd),
    .rd_add(rd_add),
    .out   (dout)
  );

  always #5 clk = ~clk;

  // Behavioural model: sparse memory, valid set, and the value out must show.
  logic [63:0] mdl_mem [int];
  bit          mdl_valid [int];
  logic [63:0] exp_out = '0;
  bit          exp_known = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge rst) begin
    exp_out   = '0;
    exp_known = 1'b1;
    mdl_valid.delete();
  end

  always @(posedge clk) begin
    if (rst) begin
      exp_out   = '0;
      exp_known = 1'b1;
    end else begin
      if (rd) begin
        if (wr && wr_add == rd_add) begin
          exp_out   = din;
          exp_known = 1'b1;
        end else begin
`ifdef RAM_INIT_VALID_EN
          exp_known = 1'b1;
          exp_out   = mdl_valid.exists(int'(rd_add)) ? mdl_mem[int'(rd_add)] : 64'h0;
`else
          exp_known = mdl_mem.exists(int'(rd_add));
          exp_out   = exp_known ? mdl_mem[int'(rd_add)] : 64'h0;
`endif
        end
      end
      if (wr) begin
        mdl_mem[int'(wr_add)]   = din;
        mdl_valid[int'(wr_add)] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (exp_known) chk("model", dout, exp_out);
  end

  task automatic step(input bit w, input logic [11:0] wa, input logic [63:0] d,
                      input bit r, input logic [11:0] ra);
    @(negedge clk);
    wr = w; wr_add = wa; din = d; rd = r; rd_add = ra;
  endtask

  task automatic check_lit(input string name, input logic [63:0] req);
    @(posedge clk);
    #1;
    chk(name, dout, req);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst = 1'b1;
    #1 chk("reset_out", dout, 64'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    step(1, 12'h005, 64'h0123_4567_89AB_CDEF, 0, 12'h000);
    step(0, 12'h000, 64'h0, 1, 12'h005);
    check_lit("wr_rd_005", 64'h0123_4567_89AB_CDEF);

    step(1, 12'h000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 12'h000);
    step(1, 12'hFFF, 64'hA5A5_A5A5_A5A5_A5A5, 0, 12'h000);
    step(0, 12'h000, 64'h0, 1, 12'h000);
    check_lit("bnd_000", 64'hFFFF_FFFF_FFFF_FFFF);
    step(0, 12'h000, 64'h0, 1, 12'hFFF);
    check_lit("bnd_fff", 64'hA5A5_A5A5_A5A5_A5A5);

    step(1, 12'h010, 64'h2222, 0, 12'h000);
    step(1, 12'h010, 64'h1111, 1, 12'h010);
    check_lit("collide", 64'h1111);
    step(0, 12'h000, 64'h0, 1, 12'h010);
    check_lit("collide_mem", 64'h1111);

    step(1, 12'h020, 64'h3333, 1, 12'h005);
    check_lit("indep", 64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 3; i++) begin
      step(0, 12'h000, 64'h0, 0, 12'h020);
      check_lit("hold", 64'h0123_4567_89AB_CDEF);
    end
    step(0, 12'h000, 64'h0, 1, 12'h020);
    check_lit("indep_wr", 64'h3333);

    step(1, 12'h030, 64'hDEAD_BEEF_0000_0001, 0, 12'h000);
    step(0, 12'h000, 64'h0, 1, 12'h030);
    check_lit("pre_rst", 64'hDEAD_BEEF_0000_0001);
    step(1, 12'h030, 64'h9999, 1, 12'h030);
    #2 rst = 1'b1;
    #1 chk("rst_async", dout, 64'h0);
    repeat (2) @(posedge clk);
    #1 chk("rst_hold", dout, 64'h0);
    @(negedge clk);
    rst = 1'b0; wr = 1'b0; rd = 1'b1; rd_add = 12'h030;
    check_lit("rst_drop_wr", 64'hDEAD_BEEF_0000_0001);

    for (int i = 0; i < 32; i++) step(1, 12'(i + 64), 64'(i) * 64'h0101_0101, 0, 12'h000);
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), 12'($urandom_range(64, 95)), {$urandom, $urandom},
           1'($urandom_range(0, 1)), 12'($urandom_range(64, 95)));
    end
    step(0, 12'h000, 64'h0, 0, 12'h000);

`ifdef RAM_INIT_VALID_EN
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    step(0, 12'h000, 64'h0, 1, 12'h100);
    check_lit("valid_unwritten", 64'h0);
    step(1, 12'h100, 64'h77, 0, 12'h000);
    step(0, 12'h000, 64'h0, 1, 12'h100);
    check_lit("valid_written", 64'h77);
    @(negedge clk) begin rst = 1'b1; rd = 1'b0; end
    @(negedge clk) rst = 1'b0;
    step(0, 12'h000, 64'h0, 1, 12'h100);
    check_lit("valid_cleared", 64'h0);
    step(0, 12'h000, 64'h0, 0, 12'h000);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
